// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared types and constants for the scoreboarded register file
package regfile_scoreboard_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } regfileState_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_read_port.sv
// rtl/regfile_scoreboard_read_port.sv - one async read port: range/zero-reg masking and writeback bypass
module regfile_scoreboard_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addrWidth(DEPTH)
) (
  input  logic                         ready,
  input  logic [AW-1:0]                readAddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regFile,
  input  logic [DEPTH-1:0]             busyVec,
  input  logic                         writeOk,
  input  logic [AW-1:0]                writeAddr,
  input  logic [WIDTH-1:0]             writeData,
  output logic [WIDTH-1:0]             readData,
  output logic                         readBusy
);

  localparam logic [AW:0] DepthLim = (AW+1)'(DEPTH);

  logic          inRange;
  logic          isZero;
  logic          valid;
  logic          hit;
  logic [AW-1:0] idx;

  assign inRange = {1'b0, readAddr} < DepthLim;
  assign isZero  = (ZERO_REG != 0) && (readAddr == '0);
  assign valid   = ready && inRange && !isZero;
  // Out-of-range addresses are steered to entry 0 so the array index stays legal; the result is masked anyway.
  assign idx     = inRange ? readAddr : '0;
  assign hit     = (BYPASS != 0) && writeOk && (readAddr == writeAddr);

  always_comb begin
    readData = '0;
    readBusy = 1'b0;
    if (valid) begin
      if (hit) begin
        readData = writeData;
        readBusy = 1'b0;
      end else begin
        readData = regFile[idx];
        readBusy = busyVec[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with busy scoreboard, bypass and post-reset clear sweep
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = addrWidth(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]       ReadBusy,
  input  logic [WIDTH-1:0]       WriteData,
  input  logic [AW-1:0]          WriteRegister,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          ReserveRegister,
  input  logic                   Reserve,
  output logic                   Ready
);

  localparam logic [AW:0]   DepthLim = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  regfileState_e               state;
  regfileState_e               stateNext;
  logic [AW-1:0]               sweepCount;
  logic [DEPTH-1:0][WIDTH-1:0] regFile;
  logic [DEPTH-1:0]            busy;
  logic                        ready;
  logic                        sweepEn;
  logic                        writeOk;
  logic                        reserveOk;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    sweepEn   = 1'b0;
    case (state)
      ST_CLEAR: begin
        sweepEn = 1'b1;
        if (sweepCount == LastAddr) begin
          stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
      end
      default: begin
        stateNext = ST_CLEAR;
      end
    endcase
  end

  assign Ready = ready;

  assign writeOk   = ready && RegWrite && ({1'b0, WriteRegister} < DepthLim) &&
                     !((ZERO_REG != 0) && (WriteRegister == '0));
  assign reserveOk = ready && Reserve && ({1'b0, ReserveRegister} < DepthLim) &&
                     !((ZERO_REG != 0) && (ReserveRegister == '0));

  // Data flops carry no reset: the sweep is what initialises them.
  always_ff @(posedge Clk) begin
    if (sweepEn) begin
      regFile[sweepCount] <= '0;
    end else if (writeOk) begin
      regFile[WriteRegister] <= WriteData;
    end
  end

  // Reserve is applied after the writeback clear so a new producer wins on the same register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sweepCount <= '0;
      busy       <= '0;
    end else begin
      if (sweepEn) begin
        sweepCount <= sweepCount + 1'b1;
      end
      if (writeOk) begin
        busy[WriteRegister] <= 1'b0;
      end
      if (reserveOk) begin
        busy[ReserveRegister] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : gRead
    regfile_scoreboard_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) uPort (
      .ready     (ready),
      .readAddr  (ReadRegister[k*AW +: AW]),
      .regFile   (regFile),
      .busyVec   (busy),
      .writeOk   (writeOk),
      .writeAddr (WriteRegister),
      .writeData (WriteData),
      .readData  (ReadData[k*WIDTH +: WIDTH]),
      .readBusy  (ReadBusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed scoreboard bench for bypassed, unbypassed and narrow register files
module tb_regfile_scoreboard;

  localparam int S_RDY = 0;
  localparam int S_DA  = 1;
  localparam int S_DB  = 2;
  localparam int S_BA  = 3;
  localparam int S_BB  = 4;
  localparam int S_DC  = 5;
  localparam int S_BC  = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] value;
  } exp_t;

  exp_t sbq[$];
  int   testCount = 0;
  int   failCount = 0;

  logic        Clk = 1'b0;
  logic        Reset;

  logic [9:0]  rrAB;
  logic [63:0] dataA, dataB;
  logic [1:0]  busyA, busyB;
  logic [31:0] wd;
  logic [4:0]  wr;
  logic        rw;
  logic [4:0]  resReg;
  logic        res;
  logic        rdyA, rdyB;

  logic [19:0] rrC;
  logic [63:0] dataC;
  logic [3:0]  busyC;
  logic [15:0] wdC;
  logic [4:0]  wrC;
  logic        rwC;
  logic [4:0]  resRegC;
  logic        resC;
  logic        rdyC;

  regfile_scoreboard #(.BYPASS(1)) dutA (
    .Clk(Clk), .Reset(Reset), .ReadRegister(rrAB), .ReadData(dataA), .ReadBusy(busyA),
    .WriteData(wd), .WriteRegister(wr), .RegWrite(rw),
    .ReserveRegister(resReg), .Reserve(res), .Ready(rdyA)
  );

  regfile_scoreboard #(.BYPASS(0)) dutB (
    .Clk(Clk), .Reset(Reset), .ReadRegister(rrAB), .ReadData(dataB), .ReadBusy(busyB),
    .WriteData(wd), .WriteRegister(wr), .RegWrite(rw),
    .ReserveRegister(resReg), .Reserve(res), .Ready(rdyB)
  );

  regfile_scoreboard #(.WIDTH(16), .DEPTH(24), .NREAD(4)) dutC (
    .Clk(Clk), .Reset(Reset), .ReadRegister(rrC), .ReadData(dataC), .ReadBusy(busyC),
    .WriteData(wdC), .WriteRegister(wrC), .RegWrite(rwC),
    .ReserveRegister(resRegC), .Reserve(resC), .Ready(rdyC)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      S_RDY:   return {61'b0, rdyC, rdyB, rdyA};
      S_DA:    return dataA;
      S_DB:    return dataB;
      S_BA:    return {62'b0, busyA};
      S_BB:    return {62'b0, busyB};
      S_DC:    return dataC;
      S_BC:    return {60'b0, busyC};
      default: return 64'hx;
    endcase
  endfunction

  task automatic expect_(input string tag, input int sel, input logic [63:0] value);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.value = value;
    sbq.push_back(e);
  endtask

  task automatic checkAll();
    exp_t        e;
    logic [63:0] got;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = obs(e.sel);
      testCount++;
      assert (got === e.value) else begin
        failCount++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", testCount);
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    rrAB = '0; wd = '0; wr = '0; rw = 1'b0; resReg = '0; res = 1'b0;
    rrC = '0; wdC = '0; wrC = '0; rwC = 1'b0; resRegC = '0; resC = 1'b0;

    // Reset held: every output is zero
    @(posedge Clk);
    tick();
    expect_("rst_ready", S_RDY, 64'h0);
    expect_("rst_dataA", S_DA, 64'h0);
    expect_("rst_dataB", S_DB, 64'h0);
    expect_("rst_busyA", S_BA, 64'h0);
    expect_("rst_dataC", S_DC, 64'h0);
    checkAll();

    // Partial sweep, then a reset pulse restarts it
    Reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_("sweep1_ready", S_RDY, 64'h0);
      checkAll();
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_("sweep2_ready", S_RDY, {61'b0, 1'(i >= 24), 1'(i >= 32), 1'(i >= 32)});
      checkAll();
    end

    // Every register cleared and idle
    for (int a = 0; a < 32; a++) begin
      tick();
      rrAB = {5'(31 - a), 5'(a)};
      expect_("clear_dataA", S_DA, 64'h0);
      expect_("clear_dataB", S_DB, 64'h0);
      expect_("clear_busyA", S_BA, 64'h0);
      expect_("clear_busyB", S_BB, 64'h0);
      checkAll();
    end

    // Basic write, then readback on both ports
    tick();
    rrAB = '0; wr = 5'd5; wd = 32'hDEADBEEF; rw = 1'b1;
    checkAll();
    tick();
    rw = 1'b0; rrAB = {5'd5, 5'd5};
    expect_("r5_dataA", S_DA, {32'hDEADBEEF, 32'hDEADBEEF});
    expect_("r5_dataB", S_DB, {32'hDEADBEEF, 32'hDEADBEEF});
    checkAll();

    // Register zero ignores writes, even when bypassed
    tick();
    rrAB = '0; wr = 5'd0; wd = 32'h1234; rw = 1'b1;
    expect_("r0_bypass_dataA", S_DA, 64'h0);
    checkAll();
    tick();
    rw = 1'b0;
    expect_("r0_dataA", S_DA, 64'h0);
    expect_("r0_dataB", S_DB, 64'h0);
    checkAll();

    // Same-cycle forwarding vs stored value
    tick();
    rrAB = {5'd5, 5'd7}; wr = 5'd7; wd = 32'hA5A5A5A5; rw = 1'b1;
    expect_("r7_bypass_dataA", S_DA, {32'hDEADBEEF, 32'hA5A5A5A5});
    expect_("r7_nobypass_dataB", S_DB, {32'hDEADBEEF, 32'h0});
    checkAll();
    tick();
    rw = 1'b0;
    expect_("r7_next_dataA", S_DA, {32'hDEADBEEF, 32'hA5A5A5A5});
    expect_("r7_next_dataB", S_DB, {32'hDEADBEEF, 32'hA5A5A5A5});
    checkAll();

    // Reserve then writeback clears busy
    tick();
    rrAB = {5'd3, 5'd7}; resReg = 5'd3; res = 1'b1;
    expect_("r3_res_same_busyA", S_BA, 64'h0);
    expect_("r3_res_same_busyB", S_BB, 64'h0);
    checkAll();
    tick();
    res = 1'b0;
    expect_("r3_busyA", S_BA, 64'h2);
    expect_("r3_busyB", S_BB, 64'h2);
    checkAll();
    tick();
    wr = 5'd3; wd = 32'h33; rw = 1'b1;
    expect_("r3_wb_busyA", S_BA, 64'h0);
    expect_("r3_wb_busyB", S_BB, 64'h2);
    expect_("r3_wb_dataA", S_DA, {32'h33, 32'hA5A5A5A5});
    expect_("r3_wb_dataB", S_DB, {32'h0, 32'hA5A5A5A5});
    checkAll();
    tick();
    rw = 1'b0;
    expect_("r3_after_busyA", S_BA, 64'h0);
    expect_("r3_after_busyB", S_BB, 64'h0);
    expect_("r3_after_dataB", S_DB, {32'h33, 32'hA5A5A5A5});
    checkAll();

    // Reserve and writeback of the same register: new producer keeps it busy
    tick();
    rrAB = {5'd9, 5'd0}; resReg = 5'd9; res = 1'b1; wr = 5'd9; wd = 32'h99; rw = 1'b1;
    expect_("r9_same_dataA", S_DA, {32'h99, 32'h0});
    checkAll();
    tick();
    res = 1'b0; rw = 1'b0;
    expect_("r9_dataA", S_DA, {32'h99, 32'h0});
    expect_("r9_dataB", S_DB, {32'h99, 32'h0});
    expect_("r9_busyA", S_BA, 64'h2);
    expect_("r9_busyB", S_BB, 64'h2);
    checkAll();

    // Reserving register zero has no effect
    tick();
    resReg = 5'd0; res = 1'b1;
    checkAll();
    tick();
    res = 1'b0; rrAB = '0;
    expect_("r0_res_busyA", S_BA, 64'h0);
    expect_("r0_res_busyB", S_BB, 64'h0);
    checkAll();

    // Narrow four-port instance: out-of-range reads and shared address
    tick();
    rrC = {5'd2, 5'd2, 5'd31, 5'd25};
    expect_("c_range_data", S_DC, 64'h0);
    expect_("c_range_busy", S_BC, 64'h0);
    checkAll();
    tick();
    rrC = {5'd2, 5'd2, 5'd2, 5'd2}; wrC = 5'd2; wdC = 16'hBEEF; rwC = 1'b1;
    expect_("c_r2_bypass", S_DC, {4{16'hBEEF}});
    checkAll();
    tick();
    rwC = 1'b0; resRegC = 5'd2; resC = 1'b1;
    expect_("c_r2_data", S_DC, {4{16'hBEEF}});
    expect_("c_r2_idle", S_BC, 64'h0);
    checkAll();
    tick();
    resC = 1'b0; rrC = {5'd25, 5'd2, 5'd2, 5'd2};
    expect_("c_r2_busy", S_BC, 64'h7);
    expect_("c_mixed_data", S_DC, {16'h0, 16'hBEEF, 16'hBEEF, 16'hBEEF});
    checkAll();

    // Reset during run drops everything back to idle
    tick();
    Reset = 1'b1;
    rrAB = {5'd9, 5'd5};
    tick();
    expect_("rerst_ready", S_RDY, 64'h0);
    expect_("rerst_dataA", S_DA, 64'h0);
    expect_("rerst_busyA", S_BA, 64'h0);
    checkAll();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
